// File: rtl/key_debounce.sv
// Pushbutton conditioner: synchronizes the active-low key, debounces it with a timed FSM and
// emits a stable level, press/release/long-press strobes and a wrapping press counter.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned LONG_CYCLES     = 50_000_000,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             KEY_N,
    output logic             pressed,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             long_pulse,
    output logic [CNT_W-1:0] press_count
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DbLast   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HoldMax  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HoldFire = HW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPressChk,
        StHeld,
        StReleaseChk
    } state_e;

    state_e           state_q;
    logic [1:0]       sync_q;
    logic [DW-1:0]    db_q;
    logic [HW-1:0]    hold_q;
    logic [HW-1:0]    hold_d;
    logic             fired_q;
    logic             pressed_q;
    logic             press_pulse_q;
    logic             release_pulse_q;
    logic             long_pulse_q;
    logic [CNT_W-1:0] press_count_q;
    logic             k;

    assign k = sync_q[1];

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], KEY_N};
        end
    end

    // Hold timer saturates so a very long press cannot wrap and re-fire.
    always_comb begin
        hold_d = hold_q;
        if (hold_q != HoldMax) begin
            hold_d = hold_q + HW'(1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q         <= StIdle;
            db_q            <= '0;
            hold_q          <= '0;
            fired_q         <= 1'b0;
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            long_pulse_q    <= 1'b0;
            press_count_q   <= '0;
        end else begin
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            long_pulse_q    <= 1'b0;

            if (state_q == StHeld || state_q == StReleaseChk) begin
                hold_q <= hold_d;
                if (hold_d == HoldFire && !fired_q) begin
                    long_pulse_q <= 1'b1;
                    fired_q      <= 1'b1;
                end
            end

            case (state_q)
                StIdle: begin
                    if (!k) begin
                        state_q <= StPressChk;
                        db_q    <= '0;
                    end
                end
                StPressChk: begin
                    if (k) begin
                        state_q <= StIdle;
                    end else if (db_q == DbLast) begin
                        state_q       <= StHeld;
                        pressed_q     <= 1'b1;
                        press_pulse_q <= 1'b1;
                        press_count_q <= press_count_q + CNT_W'(1);
                        hold_q        <= '0;
                        fired_q       <= 1'b0;
                    end else begin
                        db_q <= db_q + DW'(1);
                    end
                end
                StHeld: begin
                    if (k) begin
                        state_q <= StReleaseChk;
                        db_q    <= '0;
                    end
                end
                StReleaseChk: begin
                    if (!k) begin
                        state_q <= StHeld;
                    end else if (db_q == DbLast) begin
                        state_q         <= StIdle;
                        pressed_q       <= 1'b0;
                        release_pulse_q <= 1'b1;
                    end else begin
                        db_q <= db_q + DW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign long_pulse    = long_pulse_q;
    assign press_count   = press_count_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: run-length reference model compared every cycle, plus literal
// latency/count expectations from the directed scenarios and a randomized bounce phase.
module tb_key_debounce;

    localparam int unsigned D = 4;
    localparam int unsigned L = 20;
    localparam int unsigned W = 2;

    logic         CLOCK_50 = 1'b0;
    logic         reset    = 1'b1;
    logic         KEY_N    = 1'b1;
    logic         pressed;
    logic         press_pulse;
    logic         release_pulse;
    logic         long_pulse;
    logic [W-1:0] press_count;

    key_debounce #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L),
        .CNT_W          (W)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .KEY_N        (KEY_N),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .press_count  (press_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    bit chk_en = 1'b0;

    // Observed DUT pulse history.
    int n_press = 0, n_release = 0, n_long = 0;
    int last_press = -1, last_release = -1, last_long = -1;

    // Reference model state: k is KEY_N two samples late; an edge accepts a level change once
    // the synchronized key has shown the new level for D+1 consecutive samples.
    logic m_s1 = 1'b1, m_s2 = 1'b1;
    int   m_run = 0, m_since = 0, m_cnt = 0;
    bit   m_pressed = 1'b0, m_pp = 1'b0, m_rp = 1'b0, m_lp = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc_n, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic key);
        logic k;
        if (r) begin
            m_s1 = 1'b1; m_s2 = 1'b1;
            m_run = 0; m_since = 0; m_cnt = 0;
            m_pressed = 1'b0; m_pp = 1'b0; m_rp = 1'b0; m_lp = 1'b0;
        end else begin
            k = m_s2;
            m_s2 = m_s1;
            m_s1 = key;
            m_pp = 1'b0; m_rp = 1'b0; m_lp = 1'b0;
            if (m_pressed) begin
                m_since++;
                if (m_since == int'(L) - 1) m_lp = 1'b1;
            end
            // Held key reads k=0, so the level that challenges the current phase equals m_pressed.
            if (k == m_pressed) m_run++;
            else m_run = 0;
            if (m_run == int'(D) + 1) begin
                m_run = 0;
                if (!m_pressed) begin
                    m_pressed = 1'b1;
                    m_pp = 1'b1;
                    m_cnt = (m_cnt + 1) % (1 << W);
                    m_since = 0;
                end else begin
                    m_pressed = 1'b0;
                    m_rp = 1'b1;
                end
            end
        end
    endtask

    task automatic cyc(input logic r, input logic key);
        reset = r;
        KEY_N = key;
        @(posedge CLOCK_50);
        cyc_n++;
        model_step(r, key);
        @(negedge CLOCK_50);
        #1;
    endtask

    task automatic hold(input int n, input logic r, input logic key);
        for (int i = 0; i < n; i++) cyc(r, key);
    endtask

    always @(negedge CLOCK_50) begin
        if (chk_en) begin
            chk("pressed", int'(pressed), int'(m_pressed));
            chk("press_pulse", int'(press_pulse), int'(m_pp));
            chk("release_pulse", int'(release_pulse), int'(m_rp));
            chk("long_pulse", int'(long_pulse), int'(m_lp));
            chk("press_count", int'(press_count), m_cnt);
            if (press_pulse === 1'b1) begin n_press++; last_press = cyc_n; end
            if (release_pulse === 1'b1) begin n_release++; last_release = cyc_n; end
            if (long_pulse === 1'b1) begin n_long++; last_long = cyc_n; end
        end
    end

    initial begin
        int e, np, nr, nl, lvl, len, exp_cnt;
        bit rr;

        hold(3, 1'b1, 1'b1);
        chk_en = 1'b1;
        chk("reset_pressed", int'(pressed), 0);
        chk("reset_count", int'(press_count), 0);

        // Idle with key released.
        hold(50, 1'b0, 1'b1);
        chk("idle_no_pulses", n_press + n_release + n_long, 0);

        // Clean press and release.
        e = cyc_n + 1;
        hold(10, 1'b0, 1'b0);
        chk("clean_press_edge", last_press, e + 6);
        chk("clean_pressed", int'(pressed), 1);
        chk("clean_count", int'(press_count), 1);
        e = cyc_n + 1;
        hold(10, 1'b0, 1'b1);
        chk("clean_release_edge", last_release, e + 6);
        chk("clean_released", int'(pressed), 0);

        // Press bounce never accepted.
        np = n_press;
        for (int i = 0; i < 5; i++) begin
            hold(2, 1'b0, 1'b0);
            hold(2, 1'b0, 1'b1);
        end
        hold(10, 1'b0, 1'b1);
        chk("bounce_no_press", n_press, np);
        chk("bounce_count", int'(press_count), 1);
        chk("bounce_pressed", int'(pressed), 0);

        // Release bounce while held.
        hold(10, 1'b0, 1'b0);
        nr = n_release;
        hold(2, 1'b0, 1'b1);
        hold(3, 1'b0, 1'b0);
        chk("rel_bounce_pressed", int'(pressed), 1);
        chk("rel_bounce_no_release", n_release, nr);
        nl = n_long;
        hold(10, 1'b0, 1'b1);
        chk("rel_bounce_no_long", n_long, nl);
        chk("rel_bounce_count", int'(press_count), 2);

        // Long press: exactly one long pulse, L-1 edges after the press pulse.
        nl = n_long;
        e = cyc_n + 1;
        hold(40, 1'b0, 1'b0);
        chk("long_edge", last_long, e + 6 + int'(L) - 1);
        chk("long_once", n_long, nl + 1);
        hold(10, 1'b0, 1'b1);

        // Short press: no long pulse, count wraps to 0.
        nl = n_long;
        hold(10, 1'b0, 1'b0);
        hold(10, 1'b0, 1'b1);
        chk("short_no_long", n_long, nl);
        chk("wrap_start", int'(press_count), 0);

        // Five presses: 1, 2, 3, 0, 1.
        exp_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            hold(8, 1'b0, 1'b0);
            hold(8, 1'b0, 1'b1);
            exp_cnt = (exp_cnt + 1) % 4;
            chk("wrap_count", int'(press_count), exp_cnt);
        end

        // Reset while held.
        hold(10, 1'b0, 1'b0);
        chk("pre_reset_pressed", int'(pressed), 1);
        nr = n_release;
        cyc(1'b1, 1'b0);
        chk("reset_drop_pressed", int'(pressed), 0);
        chk("reset_drop_count", int'(press_count), 0);
        chk("reset_no_release", n_release, nr);
        e = cyc_n + 1;
        hold(10, 1'b0, 1'b0);
        chk("repress_edge", last_press, e + 6);
        chk("repress_count", int'(press_count), 1);
        hold(10, 1'b0, 1'b1);

        // Randomized bouncing, long holds and occasional resets.
        for (int seg = 0; seg < 300; seg++) begin
            lvl = int'($urandom_range(0, 1));
            len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(20, 45))
                                              : int'($urandom_range(1, 8));
            rr = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < len; i++) cyc(rr && i == 0, lvl[0]);
        end
        hold(12, 1'b0, 1'b1);
        chk("final_released", int'(pressed), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
# key_debounce

Input-side counterpart to the LED blinker: conditions one raw board pushbutton into clean, single-cycle events that downstream logic can use to drive LED patterns. It synchronizes the asynchronous active-low key, debounces it with a timed state machine, and reports the following:
- stable pressed level
- press, release and long-press pulses
- a wrapping press counter

It sits between the board KEY pin and any user-control logic on the CLOCK_50 domain.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000: cycles the key must stay stable before a press or release is accepted (20 ms at 50 MHz); legal range ≥ 2.
- LONG_CYCLES, 50_000_000: cycles after press acceptance before long_pulse fires (1 s); legal range ≥ 2.
- CNT_W, 8: width of press_count.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz; one clock domain; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- KEY_N  in  1  raw pushbutton; active-low; asynchronous and bouncing.
- pressed  out  1  debounced key level; 1 = held.
- press_pulse  out  1  one-cycle strobe when a press is accepted.
- release_pulse  out  1  one-cycle strobe when a release is accepted.
- long_pulse  out  1  one-cycle strobe, at most once per press.
- press_count  out  CNT_W  number of accepted presses, modulo 2^CNT_W.

## Operation
- Synchronizer: 2-flop chain on KEY_N. Both flops reset to 1 (released). The FSM uses only the second flop output, called `k`.
- Debounce timer: width $clog2(DEBOUNCE_CYCLES). Hold timer: width $clog2(LONG_CYCLES+1), saturating.
- FSM states and transitions:
  - IDLE:
    - k=0 → PRESS_CHK, debounce timer cleared to 0.
  - PRESS_CHK:
    - k=1 → IDLE. Bounce; no outputs.
    - Otherwise the timer increments.
    - On the edge where timer = DEBOUNCE_CYCLES-1 and k=0:
      - go to HELD
      - pressed←1, press_pulse←1
      - press_count increments, wrapping from 2^CNT_W-1 to 0
      - hold timer←0, long-fired flag←0
  - HELD:
    - Hold timer increments each cycle.
    - k=1 → RELEASE_CHK, debounce timer cleared to 0.
  - RELEASE_CHK:
    - Hold timer keeps counting.
    - k=0 → HELD. Bounce; pressed stays 1; no pulse.
    - Otherwise the timer increments.
    - On the edge where timer = DEBOUNCE_CYCLES-1 and k=1:
      - go to IDLE
      - pressed←0, release_pulse←1
- Long press:
  - In HELD or RELEASE_CHK, on the edge where the hold timer reaches LONG_CYCLES-1 and the long-fired flag is 0: long_pulse←1 and the flag is set.
  - The hold timer saturates. long_pulse never repeats within one press.
  - A press released before LONG_CYCLES produces no long_pulse.
- All pulses are registered and high for exactly one cycle. They default to 0 in every other cycle.
- The state encoding is internal. There are no unreachable-state lockups: any illegal state returns to IDLE on the next edge.

## Timing
- Reset values:
  - state IDLE
  - pressed 0, all pulses 0, press_count 0
  - timers 0, long-fired flag 0
  - both sync flops 1
- Reset asserted mid-press (any state) drops pressed to 0 on the next edge without emitting release_pulse. A key still held after reset deasserts is re-debounced from IDLE and counted as a new press.
- Press latency:
  - KEY_N is sampled low at edge E.
  - `k`=0 after E+1; PRESS_CHK is entered at E+2.
  - press_pulse and pressed rise at edge E+2+DEBOUNCE_CYCLES, provided KEY_N stays low throughout.
- Release latency: same shape. release_pulse and pressed=0 at edge E+2+DEBOUNCE_CYCLES after KEY_N is sampled high.
- Long-press latency: long_pulse at press_pulse edge + LONG_CYCLES-1 edges.
- A bounce shorter than DEBOUNCE_CYCLES restarts the check. It never produces a pulse.
- press_pulse and long_pulse never assert in the same cycle (LONG_CYCLES ≥ 2).
- press_count updates in the same cycle as press_pulse.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, LONG_CYCLES=20, CNT_W=2.

- Reset → all outputs 0 and press_count=0. Hold KEY_N=1 for 50 cycles → no pulses.
- Clean press: KEY_N→0 sampled at edge E, then held 10 cycles → press_pulse high only at E+6; pressed=1 from E+6; press_count=1. Clean release then → release_pulse 6 edges after KEY_N is sampled high.
- Bounce: KEY_N toggles low/high every 2 cycles for 20 cycles, then settles high → no pulses, pressed=0, press_count unchanged. Release bounce (KEY_N=1 for 2 cycles while HELD) → pressed stays 1, no release_pulse.
- Long press: hold KEY_N=0 for 40 cycles → exactly one long_pulse, 19 edges after press_pulse. A second press held for 10 cycles → no long_pulse.
- Wrap: 5 clean presses → press_count reads 1, 2, 3, 0, 1.
- Reset mid-HELD: assert reset while pressed=1 → next edge pressed=0, count 0, no release_pulse. Key still low after reset → new press_pulse at reset-release edge + 6.
